// File: rtl/io_periph_pkg.sv
// ---------------------------------------------------------------------------
// io_pkg
// Shared definitions for the I/O peripheral bank: region selects, register
// offsets within each region, the blank seven-segment pattern and a helper
// that merges a byte-masked store into an existing word.
// ---------------------------------------------------------------------------
package io_pkg;

  // Upper address halfword of the output and input regions
  localparam logic [15:0] IO_OUT = 16'h1000;
  localparam logic [15:0] IO_IN  = 16'h1001;

  // All segments off (segments are active-low)
  localparam logic [6:0] HEX_BLANK = 7'h7F;

  // Register offsets (addr[14:12]) inside the output region
  typedef enum logic [2:0] {
    REG_LEDR   = 3'd0,
    REG_LEDG   = 3'd1,
    REG_HEX_LO = 3'd2,
    REG_HEX_HI = 3'd3,
    REG_LCD    = 3'd4
  } io_reg_e;

  // Register offsets (addr[14:12]) inside the input region
  typedef enum logic [2:0] {
    REG_SW       = 3'd0,
    REG_KEY      = 3'd1,
    REG_KEY_EDGE = 3'd2
  } io_in_reg_e;

  // Replace each byte lane of oldWord whose mask bit is set with the
  // corresponding lane of newWord
  function automatic logic [31:0] mergeLanes(input logic [31:0] oldWord,
                                             input logic [31:0] newWord,
                                             input logic [3:0]  mask);
    logic [31:0] result;
    result = oldWord;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) result[8*b +: 8] = newWord[8*b +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/io_periph_if.sv
// ---------------------------------------------------------------------------
// io_periph_if
// Load/store bus between the LSU address decoder (master) and the I/O
// peripheral bank (slave).
//   io_valid  access targets the I/O region
//   io_wren   store to the I/O region (already qualified by io_valid)
//   lsu_addr  byte address; [16] picks out/in region, [14:12] the register
//   st_data   byte-lane aligned store data
//   bmask     byte-lane write mask
//   io_rdata  registered load data, valid one cycle after the access
// ---------------------------------------------------------------------------
interface io_periph_if;
  logic        io_valid;
  logic        io_wren;
  logic [31:0] lsu_addr;
  logic [31:0] st_data;
  logic [3:0]  bmask;
  logic [31:0] io_rdata;

  modport master (
    output io_valid, io_wren, lsu_addr, st_data, bmask,
    input  io_rdata
  );

  modport slave (
    input  io_valid, io_wren, lsu_addr, st_data, bmask,
    output io_rdata
  );
endinterface

// File: rtl/io_periph_key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// One push-button: two-flop synchroniser of the inverted (active-low) raw key
// followed by a hold-time debouncer.
//   i_clk, i_reset  clock / synchronous active-high reset
//   i_key_n         raw key, active-low, asynchronous
//   o_stable        debounced level, 1 = pressed
//   o_press         one-cycle pulse in the cycle a press is being accepted
// ---------------------------------------------------------------------------
module key_debounce #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_key_n,
  output logic o_stable,
  output logic o_press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q, stable_q;
  logic [CW-1:0] cnt_q;

  // The counter only runs while the synchronised level disagrees with the
  // accepted level; any return to agreement restarts it, so a glitch shorter
  // than DEB_CYCLES can never reach the accept point.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= ~i_key_n;
      sync2_q <= sync1_q;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= sync2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign o_stable = stable_q;

  // High in the cycle whose closing edge flips stable from released to pressed
  assign o_press = sync2_q & ~stable_q & (cnt_q == CNT_LAST);

endmodule

// File: rtl/io_periph.sv
// ---------------------------------------------------------------------------
// io_periph
// Memory-mapped peripheral bank behind the LSU decoder. Holds the LED, HEX and
// LCD output registers, synchronises the slide switches, debounces the keys,
// latches key presses into a write-1-to-clear edge register and returns
// registered load data for the 0x1000_xxxx / 0x1001_xxxx regions.
//   i_clk, i_reset      clock / synchronous active-high reset
//   bus (slave)         valid/wren/addr/store data/mask in, load data out
//   i_io_sw             raw slide switches (asynchronous)
//   i_io_key            raw keys, active-low (asynchronous)
//   o_io_ledr/ledg      red/green LEDs
//   o_io_hex0..7        seven-segment digits, active-low segments
//   o_io_lcd            LCD control/data word
// ---------------------------------------------------------------------------
module io_periph
  import io_pkg::*;
#(
  parameter int DEB_CYCLES = 50000,
  parameter int NUM_KEYS   = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  io_periph_if.slave          bus,
  input  logic [31:0]         i_io_sw,
  input  logic [NUM_KEYS-1:0] i_io_key,
  output logic [31:0]         o_io_ledr,
  output logic [31:0]         o_io_ledg,
  output logic [6:0]          o_io_hex0,
  output logic [6:0]          o_io_hex1,
  output logic [6:0]          o_io_hex2,
  output logic [6:0]          o_io_hex3,
  output logic [6:0]          o_io_hex4,
  output logic [6:0]          o_io_hex5,
  output logic [6:0]          o_io_hex6,
  output logic [6:0]          o_io_hex7,
  output logic [31:0]         o_io_lcd
);

  logic [31:0]         ledr_q, ledr_d, ledg_q, ledg_d, lcd_q, lcd_d;
  logic [7:0][6:0]     hex_q, hex_d;
  logic [31:0]         rdata_q, rdata_d, readData;
  logic [31:0]         sw1_q, sw2_q;
  logic [NUM_KEYS-1:0] keyEdge_q, keyEdge_d, keyStable, keyPress, edgeClr;
  logic                isIn, wrOut, wrIn;
  logic [2:0]          regSel;
  logic                unusedAddrBits;

  // The decoder has already picked the I/O region, so only bit 16 of the
  // upper halfword is needed to tell the two regions apart.
  assign isIn   = (bus.lsu_addr[16] == IO_IN[0]);
  assign regSel = bus.lsu_addr[14:12];
  assign wrOut  = bus.io_wren & ~isIn;
  assign wrIn   = bus.io_wren & isIn;
  assign unusedAddrBits = ^{bus.lsu_addr[31:17], bus.lsu_addr[15], bus.lsu_addr[11:0]};

  genvar k;
  generate
    for (k = 0; k < NUM_KEYS; k++) begin : gKey
      key_debounce #(.DEB_CYCLES(DEB_CYCLES)) uDeb (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_key_n  (i_io_key[k]),
        .o_stable (keyStable[k]),
        .o_press  (keyPress[k])
      );
    end
  endgenerate

  // Load mux; HEX bytes carry a zero in bit 7, unmapped offsets read zero.
  always_comb begin
    readData = '0;
    if (isIn) begin
      case (regSel)
        REG_SW:       readData = sw2_q;
        REG_KEY:      readData[NUM_KEYS-1:0] = keyStable;
        REG_KEY_EDGE: readData[NUM_KEYS-1:0] = keyEdge_q;
        default:      readData = '0;
      endcase
    end else begin
      case (regSel)
        REG_LEDR:   readData = ledr_q;
        REG_LEDG:   readData = ledg_q;
        REG_HEX_LO: readData = {1'b0, hex_q[3], 1'b0, hex_q[2], 1'b0, hex_q[1], 1'b0, hex_q[0]};
        REG_HEX_HI: readData = {1'b0, hex_q[7], 1'b0, hex_q[6], 1'b0, hex_q[5], 1'b0, hex_q[4]};
        REG_LCD:    readData = lcd_q;
        default:    readData = '0;
      endcase
    end
  end

  // Next-state for stores, the sticky edge register and the load data.
  // A press being accepted in the same cycle as a clearing store wins.
  always_comb begin
    ledr_d  = ledr_q;
    ledg_d  = ledg_q;
    lcd_d   = lcd_q;
    hex_d   = hex_q;
    rdata_d = rdata_q;
    edgeClr = '0;
    if (wrOut) begin
      case (regSel)
        REG_LEDR: ledr_d = mergeLanes(ledr_q, bus.st_data, bus.bmask);
        REG_LEDG: ledg_d = mergeLanes(ledg_q, bus.st_data, bus.bmask);
        REG_LCD:  lcd_d  = mergeLanes(lcd_q, bus.st_data, bus.bmask);
        REG_HEX_LO: begin
          for (int b = 0; b < 4; b++)
            if (bus.bmask[b]) hex_d[b] = bus.st_data[8*b +: 7];
        end
        REG_HEX_HI: begin
          for (int b = 0; b < 4; b++)
            if (bus.bmask[b]) hex_d[4+b] = bus.st_data[8*b +: 7];
        end
        default: ;
      endcase
    end
    if (wrIn && regSel == REG_KEY_EDGE && bus.bmask[0]) begin
      edgeClr = bus.st_data[NUM_KEYS-1:0];
    end
    keyEdge_d = (keyEdge_q & ~edgeClr) | keyPress;
    if (bus.io_valid && !bus.io_wren) begin
      rdata_d = readData;
    end
  end

  // All architectural state, plus the two-flop switch synchroniser.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ledr_q    <= '0;
      ledg_q    <= '0;
      lcd_q     <= '0;
      hex_q     <= {8{HEX_BLANK}};
      rdata_q   <= '0;
      sw1_q     <= '0;
      sw2_q     <= '0;
      keyEdge_q <= '0;
    end else begin
      ledr_q    <= ledr_d;
      ledg_q    <= ledg_d;
      lcd_q     <= lcd_d;
      hex_q     <= hex_d;
      rdata_q   <= rdata_d;
      sw1_q     <= i_io_sw;
      sw2_q     <= sw1_q;
      keyEdge_q <= keyEdge_d;
    end
  end

  assign bus.io_rdata = rdata_q;
  assign o_io_ledr    = ledr_q;
  assign o_io_ledg    = ledg_q;
  assign o_io_lcd     = lcd_q;
  assign o_io_hex0    = hex_q[0];
  assign o_io_hex1    = hex_q[1];
  assign o_io_hex2    = hex_q[2];
  assign o_io_hex3    = hex_q[3];
  assign o_io_hex4    = hex_q[4];
  assign o_io_hex5    = hex_q[5];
  assign o_io_hex6    = hex_q[6];
  assign o_io_hex7    = hex_q[7];

endmodule

// File: tb/tb_io_periph.sv
// ---------------------------------------------------------------------------
// tb_io_periph
// Self-checking bench for io_periph with a short debounce window.
// ---------------------------------------------------------------------------
module tb_io_periph;
  import io_pkg::*;

  localparam int DEB = 8;
  localparam int NK  = 4;

  localparam logic [31:0] A_KEY  = 32'h1001_1000;
  localparam logic [31:0] A_EDGE = 32'h1001_2000;
  localparam logic [31:0] SW_VAL = 32'hCAFE_F00D;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   sw;
  logic [NK-1:0] key;
  logic [31:0]   ledr, ledg, lcd;
  logic [6:0]    hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;

  int compared   = 0;
  int mismatched = 0;

  io_periph_if bus ();

  io_periph #(.DEB_CYCLES(DEB), .NUM_KEYS(NK)) dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .bus       (bus),
    .i_io_sw   (sw),
    .i_io_key  (key),
    .o_io_ledr (ledr),
    .o_io_ledg (ledg),
    .o_io_hex0 (hex0),
    .o_io_hex1 (hex1),
    .o_io_hex2 (hex2),
    .o_io_hex3 (hex3),
    .o_io_hex4 (hex4),
    .o_io_hex5 (hex5),
    .o_io_hex6 (hex6),
    .o_io_hex7 (hex7),
    .o_io_lcd  (lcd)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          doStore;
    logic [31:0] stAddr;
    logic [31:0] stData;
    logic [3:0]  mask;
    logic [31:0] ldAddr;
    logic [31:0] expRead;
  } vec_t;

  vec_t vecs [8];

  // Reference state for the randomized phase: plain words per register slot
  logic [31:0]   mOut [8];
  logic [NK-1:0] mEdge;
  logic [NK-1:0] mKey;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // One bus cycle; entered and left 1 time unit after a rising edge
  task automatic applyStimulus(input bit wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] mask);
    bus.io_valid = 1'b1;
    bus.io_wren  = wr;
    bus.lsu_addr = addr;
    bus.st_data  = data;
    bus.bmask    = mask;
    @(posedge clk);
    #1;
    bus.io_valid = 1'b0;
    bus.io_wren  = 1'b0;
    bus.bmask    = 4'h0;
  endtask

  task automatic doLoad(input logic [31:0] addr, output logic [31:0] data);
    applyStimulus(1'b0, addr, 32'h0, 4'h0);
    data = bus.io_rdata;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Load KEY every cycle; report on which load the key bit first reads 1
  task automatic pollKey(input int bitIdx, input int maxLoads, output int first);
    logic [31:0] d;
    first = -1;
    for (int i = 1; i <= maxLoads; i++) begin
      doLoad(A_KEY, d);
      if (d[bitIdx]) begin
        first = i;
        break;
      end
    end
  endtask

  function automatic logic [31:0] hexLoWord();
    return {1'b0, hex3, 1'b0, hex2, 1'b0, hex1, 1'b0, hex0};
  endfunction

  function automatic logic [31:0] hexHiWord();
    return {1'b0, hex7, 1'b0, hex6, 1'b0, hex5, 1'b0, hex4};
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] d;
    int          first;

    bus.io_valid = 1'b0;
    bus.io_wren  = 1'b0;
    bus.lsu_addr = 32'h0;
    bus.st_data  = 32'h0;
    bus.bmask    = 4'h0;
    sw           = SW_VAL;
    key          = '1;
    reset        = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // ---- reset state ----
    checkOutput("reset rdata", bus.io_rdata, 32'h0);
    checkOutput("reset ledr", ledr, 32'h0);
    checkOutput("reset ledg", ledg, 32'h0);
    checkOutput("reset lcd", lcd, 32'h0);
    checkOutput("reset hex lo", hexLoWord(), 32'h7F7F_7F7F);
    checkOutput("reset hex hi", hexHiWord(), 32'h7F7F_7F7F);
    doLoad(A_EDGE, d);
    checkOutput("reset key_edge", d, 32'h0);

    // ---- table-driven register vectors ----
    vecs[0] = '{"ledr masked",   1'b1, 32'h1000_0000, 32'hA5A5_1234, 4'b0101, 32'h1000_0FFC, 32'h00A5_0034};
    vecs[1] = '{"hex lo",        1'b1, 32'h1000_2000, 32'hFF80_7F01, 4'b1111, 32'h1000_2000, 32'h7F00_7F01};
    vecs[2] = '{"hex hi upper",  1'b1, 32'h1000_3000, 32'h1234_5678, 4'b1100, 32'h1000_3004, 32'h1234_7F7F};
    vecs[3] = '{"lcd",           1'b1, 32'h1000_4000, 32'hDEAD_BEEF, 4'b1111, 32'h1000_4ABC, 32'hDEAD_BEEF};
    vecs[4] = '{"unmapped out",  1'b1, 32'h1000_7000, 32'h0000_0001, 4'b1111, 32'h1000_7000, 32'h0};
    vecs[5] = '{"sw read-only",  1'b1, 32'h1001_0000, 32'hFFFF_FFFF, 4'b1111, 32'h1001_0000, SW_VAL};
    vecs[6] = '{"unmapped in",   1'b0, 32'h0,         32'h0,         4'b0000, 32'h1001_5000, 32'h0};
    vecs[7] = '{"ledg one lane", 1'b1, 32'h1000_1000, 32'h0F0F_0F0F, 4'b0010, 32'h1000_1000, 32'h0000_0F00};

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].doStore) applyStimulus(1'b1, vecs[i].stAddr, vecs[i].stData, vecs[i].mask);
      doLoad(vecs[i].ldAddr, d);
      checkOutput(vecs[i].name, d, vecs[i].expRead);
    end

    checkOutput("ledr port", ledr, 32'h00A5_0034);
    checkOutput("ledg port", ledg, 32'h0000_0F00);
    checkOutput("hex0", {25'h0, hex0}, 32'h01);
    checkOutput("hex1", {25'h0, hex1}, 32'h7F);
    checkOutput("hex2", {25'h0, hex2}, 32'h00);
    checkOutput("hex3", {25'h0, hex3}, 32'h7F);
    checkOutput("hex4", {25'h0, hex4}, 32'h7F);
    checkOutput("hex5", {25'h0, hex5}, 32'h7F);
    checkOutput("hex6", {25'h0, hex6}, 32'h34);
    checkOutput("hex7", {25'h0, hex7}, 32'h12);
    checkOutput("lcd port", lcd, 32'hDEAD_BEEF);

    // Without a load, rdata keeps the last loaded value
    idle(3);
    applyStimulus(1'b1, 32'h1000_0000, 32'h1111_1111, 4'b1111);
    checkOutput("rdata hold", bus.io_rdata, vecs[7].expRead);

    // ---- short glitch on key0 is filtered ----
    key[0] = 1'b0;
    idle(5);
    key[0] = 1'b1;
    idle(20);
    doLoad(A_KEY, d);
    checkOutput("glitch key", d, 32'h0);
    doLoad(A_EDGE, d);
    checkOutput("glitch key_edge", d, 32'h0);

    // ---- held key0: accepted on edge 2+DEB, seen by the following load ----
    key[0] = 1'b0;
    pollKey(0, 14, first);
    checkOutput("key0 accept load index", 32'(first), 32'd11);
    doLoad(A_EDGE, d);
    checkOutput("key0 edge set", d, 32'h1);
    key[0] = 1'b1;
    idle(15);
    doLoad(A_KEY, d);
    checkOutput("key0 released", d, 32'h0);
    doLoad(A_EDGE, d);
    checkOutput("key0 edge sticky", d, 32'h1);
    applyStimulus(1'b1, A_EDGE, 32'h1, 4'b0001);
    doLoad(A_EDGE, d);
    checkOutput("w1c clears", d, 32'h0);

    // Re-arm bit0, then clear both bits on the edge where key1 is accepted
    key[0] = 1'b0;
    idle(12);
    key[0] = 1'b1;
    idle(12);
    key[1] = 1'b0;
    idle(DEB + 1);
    applyStimulus(1'b1, 32'h1001_2ABC, 32'h3, 4'b0001);
    doLoad(A_EDGE, d);
    checkOutput("set beats clear", d, 32'h2);
    doLoad(A_KEY, d);
    checkOutput("key1 pressed", d, 32'h2);
    applyStimulus(1'b1, A_EDGE, 32'h2, 4'b1110);
    doLoad(A_EDGE, d);
    checkOutput("w1c needs lane0", d, 32'h2);
    key[1] = 1'b1;
    idle(15);

    // ---- reset while key2 is mid-debounce ----
    key[2] = 1'b0;
    idle(5);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    checkOutput("mid reset ledr", ledr, 32'h0);
    pollKey(2, 14, first);
    checkOutput("key2 reaccept load index", 32'(first), 32'd11);
    doLoad(A_EDGE, d);
    checkOutput("key2 edge after reset", d, 32'h4);
    key[2] = 1'b1;
    idle(15);

    // ---- randomized traffic against the reference model ----
    for (int r = 0; r < 8; r++) mOut[r] = 32'h0;
    mOut[2] = 32'h7F7F_7F7F;
    mOut[3] = 32'h7F7F_7F7F;
    mEdge   = 4'h4;
    mKey    = 4'h0;

    for (int n = 0; n < 60; n++) begin
      logic [2:0]  off;
      logic        inReg;
      logic        wr;
      logic [31:0] addr, data, expd;
      logic [3:0]  mask;
      logic [7:0]  by;

      sw = $urandom;
      idle(2);
      off   = 3'($urandom_range(0, 7));
      inReg = 1'($urandom_range(0, 1));
      wr    = 1'($urandom_range(0, 1));
      data  = $urandom;
      mask  = 4'($urandom_range(0, 15));
      addr  = {(inReg ? IO_IN : IO_OUT), 1'b0, off, 12'($urandom_range(0, 4095))};

      if (wr) begin
        applyStimulus(1'b1, addr, data, mask);
        if (!inReg && off <= 3'd4) begin
          for (int b = 0; b < 4; b++) begin
            if (mask[b]) begin
              by = data[8*b +: 8];
              if (off == 3'd2 || off == 3'd3) by[7] = 1'b0;
              mOut[off][8*b +: 8] = by;
            end
          end
        end
        if (inReg && off == 3'd2 && mask[0]) mEdge = mEdge & ~data[NK-1:0];
        checkOutput("rand ledr", ledr, mOut[0]);
        checkOutput("rand ledg", ledg, mOut[1]);
        checkOutput("rand hex lo", hexLoWord(), mOut[2]);
        checkOutput("rand hex hi", hexHiWord(), mOut[3]);
        checkOutput("rand lcd", lcd, mOut[4]);
      end else begin
        doLoad(addr, d);
        if (inReg) begin
          case (off)
            3'd0:    expd = sw;
            3'd1:    expd = {28'h0, mKey};
            3'd2:    expd = {28'h0, mEdge};
            default: expd = 32'h0;
          endcase
        end else begin
          expd = (off <= 3'd4) ? mOut[off] : 32'h0;
        end
        checkOutput("rand load", d, expd);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
